switch_event_ctrl: RTL and testbench

SWITCH_EVENT_CTRL -- requirements
Module: switch_event_ctrl

---
 rtl/switch_ctrl_pkg.sv | 15 +
 rtl/sw_debounce_lane.sv | 116 +++++++++++
 rtl/switch_event_ctrl.sv | 122 ++++++++++++
 tb/tb_switch_event_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_ctrl_pkg.sv
// Shared event-code definitions for the switch event controller.
package switch_ctrl_pkg;

  localparam int CODE_W = 2;
  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_RELEASE = 2'b00;
  localparam code_t CODE_PRESS    = 2'b01;
  localparam code_t CODE_LONG     = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_debounce_lane.sv
// One switch lane: synchronizer, debounce counter, optional hold counter, pending slot.
// Long-press hold counter is present only when SWITCH_LONG_PRESS_EN is defined.
module sw_debounce_lane
  import switch_ctrl_pkg::*;
#(
  parameter int STABLE_TICKS = 100,
  parameter int LONG_TICKS   = 10000
) (
  input  logic  i_Clk,
  input  logic  i_Rst_L,
  input  logic  tick,
  input  logic  raw_sw,
  input  logic  grant_clr,
  output logic  sw_level,
  output logic  pend_valid,
  output code_t pend_code,
  output logic  overrun_pulse
);

  localparam int CNT_MAX = max_int(STABLE_TICKS, LONG_TICKS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] SAT_C    = CNT_W'(CNT_MAX);

  logic [1:0]       sync_reg;
  logic             sw_reg, sw_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_valid_reg, pend_valid_next;
  code_t            pend_code_reg, pend_code_next;
  logic             deb_evt;
  code_t            deb_code;
  logic             long_evt;
  logic             new_evt;
  code_t            new_code;
  logic             sync_sw;

  assign sync_sw = sync_reg[1];

  always_comb begin
    sw_next  = sw_reg;
    cnt_next = cnt_reg;
    deb_evt  = 1'b0;
    deb_code = CODE_RELEASE;
    if (sync_sw == sw_reg) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg >= STABLE_C - 1'b1) begin
        sw_next  = sync_sw;
        cnt_next = '0;
        deb_evt  = 1'b1;
        deb_code = sync_sw ? CODE_PRESS : CODE_RELEASE;
      end else if (cnt_reg != SAT_C) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

`ifdef SWITCH_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TICKS);
  logic [CNT_W-1:0] hold_reg, hold_next;

  // Hold counter stops at LONG_TICKS, so the long event fires once per press.
  always_comb begin
    hold_next = hold_reg;
    long_evt  = 1'b0;
    if (!sw_reg) begin
      hold_next = '0;
    end else if (tick && (hold_reg != LONG_C)) begin
      hold_next = hold_reg + 1'b1;
      long_evt  = ((hold_reg + 1'b1) == LONG_C);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) hold_reg <= '0;
    else          hold_reg <= hold_next;
  end
`else
  assign long_evt = 1'b0;
`endif

  // A slot cleared by a grant on this edge is not an overrun.
  always_comb begin
    new_evt         = deb_evt | long_evt;
    new_code        = deb_evt ? deb_code : CODE_LONG;
    pend_valid_next = pend_valid_reg & ~grant_clr;
    pend_code_next  = pend_code_reg;
    overrun_pulse   = 1'b0;
    if (new_evt) begin
      pend_valid_next = 1'b1;
      pend_code_next  = new_code;
      overrun_pulse   = pend_valid_reg & ~grant_clr;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_reg       <= '0;
      sw_reg         <= 1'b0;
      cnt_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_code_reg  <= CODE_RELEASE;
    end else begin
      sync_reg       <= {sync_reg[0], raw_sw};
      sw_reg         <= sw_next;
      cnt_reg        <= cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_code_reg  <= pend_code_next;
    end
  end

  assign sw_level   = sw_reg;
  assign pend_valid = pend_valid_reg;
  assign pend_code  = pend_code_reg;

endmodule

// File: rtl/switch_event_ctrl.sv
// Debounced switch bank with round-robin event output and sticky overrun flag.
// Long-press events are built only with SWITCH_LONG_PRESS_EN defined.
module switch_event_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int NUM_SW       = 4,
  parameter int TICK_DIV     = 2500,
  parameter int STABLE_TICKS = 100,
  parameter int LONG_TICKS   = 10000
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [NUM_SW-1:0]         i_Switch,
  output logic [NUM_SW-1:0]         o_Switch,
  output logic                      o_Event_Valid,
  input  logic                      i_Event_Ready,
  output logic [$clog2(NUM_SW)-1:0] o_Event_Id,
  output logic [CODE_W-1:0]         o_Event_Code,
  output logic                      o_Overrun
);

  localparam int ID_W  = $clog2(NUM_SW);
  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] presc_reg, presc_next;
  logic             tick;

  logic [NUM_SW-1:0] pend_valid;
  code_t             pend_code [NUM_SW];
  logic [NUM_SW-1:0] ovr_pulse;
  logic [NUM_SW-1:0] grant_clr;

  logic [ID_W-1:0] last_grant_reg, last_grant_next;
  logic [ID_W-1:0] grant_idx, lane_idx;
  logic            grant_found;
  logic            load;

  logic            out_valid_reg, out_valid_next;
  logic [ID_W-1:0] out_id_reg, out_id_next;
  code_t           out_code_reg, out_code_next;
  logic            overrun_reg, overrun_next;

  assign tick       = (presc_reg == PRE_W'(TICK_DIV - 1));
  assign presc_next = tick ? '0 : presc_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_lane
      assign grant_clr[gi] = load && (grant_idx == ID_W'(gi));

      sw_debounce_lane #(
        .STABLE_TICKS(STABLE_TICKS),
        .LONG_TICKS  (LONG_TICKS)
      ) u_lane (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .tick         (tick),
        .raw_sw       (i_Switch[gi]),
        .grant_clr    (grant_clr[gi]),
        .sw_level     (o_Switch[gi]),
        .pend_valid   (pend_valid[gi]),
        .pend_code    (pend_code[gi]),
        .overrun_pulse(ovr_pulse[gi])
      );
    end
  endgenerate

  // Search starts one past the last grant; reset value makes lane 0 first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    lane_idx    = '0;
    for (int k = 1; k <= NUM_SW; k++) begin
      lane_idx = ID_W'((int'(last_grant_reg) + k) % NUM_SW);
      if (!grant_found && pend_valid[lane_idx]) begin
        grant_found = 1'b1;
        grant_idx   = lane_idx;
      end
    end
  end

  assign load = grant_found && (!out_valid_reg || i_Event_Ready);

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_id_next     = out_id_reg;
    out_code_next   = out_code_reg;
    last_grant_next = last_grant_reg;
    overrun_next    = overrun_reg | (|ovr_pulse);
    if (load) begin
      out_valid_next  = 1'b1;
      out_id_next     = grant_idx;
      out_code_next   = pend_code[grant_idx];
      last_grant_next = grant_idx;
    end else if (i_Event_Ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      presc_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_SW - 1);
      out_valid_reg  <= 1'b0;
      out_id_reg     <= '0;
      out_code_reg   <= CODE_RELEASE;
      overrun_reg    <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      last_grant_reg <= last_grant_next;
      out_valid_reg  <= out_valid_next;
      out_id_reg     <= out_id_next;
      out_code_reg   <= out_code_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign o_Event_Valid = out_valid_reg;
  assign o_Event_Id    = out_id_reg;
  assign o_Event_Code  = out_code_reg;
  assign o_Overrun     = overrun_reg;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Directed self-checking bench for switch_event_ctrl (TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10).
// Long-press expectations follow SWITCH_LONG_PRESS_EN.
module tb_switch_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'b0;
  logic [3:0] sw_out;
  logic       ev_valid;
  logic       ready = 1'b0;
  logic [1:0] ev_id;
  logic [1:0] ev_code;
  logic       ovr;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [1:0] id_q[$];
  logic [1:0] code_q[$];
  int         cyc_q[$];

  switch_event_ctrl #(
    .NUM_SW(4), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(10)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch     (sw),
    .o_Switch     (sw_out),
    .o_Event_Valid(ev_valid),
    .i_Event_Ready(ready),
    .o_Event_Id   (ev_id),
    .o_Event_Code (ev_code),
    .o_Overrun    (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Records every accepted event (valid and ready both high before the edge).
  always @(negedge clk) begin
    if (rst_n && ev_valid && ready) begin
      id_q.push_back(ev_id);
      code_q.push_back(ev_code);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] q_id(input int i);
    return (i < id_q.size()) ? id_q[i] : 2'bxx;
  endfunction

  function automatic logic [1:0] q_code(input int i);
    return (i < code_q.size()) ? code_q[i] : 2'bxx;
  endfunction

  function automatic int q_cyc(input int i);
    return (i < cyc_q.size()) ? cyc_q[i] : -100;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    sw    = 4'b0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    id_q.delete();
    code_q.delete();
    cyc_q.delete();
    rst_n = 1'b1;
  endtask

  // Returns just after a tick edge so settle latency is deterministic.
  task automatic align_tick();
    do @(negedge clk); while (cyc % 4 != 0);
  endtask

  initial begin
    int  n;
    logic bad;

    // Reset state
    do_reset();
    check("rst_switch", 32'(sw_out), 32'h0);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_id", 32'(ev_id), 32'h0);
    check("rst_code", 32'(ev_code), 32'h0);
    check("rst_overrun", 32'(ovr), 32'h0);

    // Single press on lane 1
    ready = 1'b1;
    align_tick();
    sw[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sw_out[1] && n < 40);
    check("press_latency_in_range", 32'(n >= 12 && n <= 16), 32'h1);
    $display("press latency %0d cycles", n);
    repeat (30) @(negedge clk);
    check("press_event_count", 32'(id_q.size()), 32'd1);
    check("press_event_id", 32'(q_id(0)), 32'd1);
    check("press_event_code", 32'(q_code(0)), 32'd1);

    // Bouncing lane 2 never settles
    do_reset();
    ready = 1'b1;
    bad   = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sw[2] = ~sw[2];
      repeat (6) begin
        @(negedge clk);
        if (sw_out !== 4'b0) bad = 1'b1;
      end
    end
    repeat (20) @(negedge clk);
    check("bounce_switch_stays_low", 32'(bad), 32'h0);
    check("bounce_no_events", 32'(id_q.size()), 32'd0);

    // Lanes 0 and 3 settle together
    do_reset();
    ready = 1'b1;
    align_tick();
    sw = 4'b1001;
    repeat (25) @(negedge clk);
    check("tie_event_count", 32'(id_q.size()), 32'd2);
    check("tie_first_id", 32'(q_id(0)), 32'd0);
    check("tie_second_id", 32'(q_id(1)), 32'd3);
    check("tie_back_to_back", 32'(q_cyc(1) - q_cyc(0)), 32'd1);
    check("tie_press_code", 32'(q_code(1)), 32'd1);
    sw = 4'b0000;
    repeat (25) @(negedge clk);
    check("wrap_event_count", 32'(id_q.size()), 32'd4);
    check("wrap_first_id", 32'(q_id(2)), 32'd0);
    check("wrap_second_id", 32'(q_id(3)), 32'd3);
    check("wrap_release_code", 32'(q_code(3)), 32'd0);

    // Backpressure with overwrite on lane 0
    do_reset();
    sw[0] = 1'b1;
    repeat (25) @(negedge clk);
    check("bp_valid", 32'(ev_valid), 32'h1);
    check("bp_code_initial", 32'(ev_code), 32'd1);
    sw[0] = 1'b0;
    repeat (25) @(negedge clk);
    check("bp_no_overrun_yet", 32'(ovr), 32'h0);
    check("bp_code_held", 32'(ev_code), 32'd1);
    sw[0] = 1'b1;
    repeat (25) @(negedge clk);
    check("bp_overrun_set", 32'(ovr), 32'h1);
    sw[0] = 1'b0;
    repeat (25) @(negedge clk);
    check("bp_id_held", 32'(ev_id), 32'd0);
    check("bp_code_still_held", 32'(ev_code), 32'd1);
    check("bp_valid_held", 32'(ev_valid), 32'h1);
    ready = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_event_count", 32'(id_q.size()), 32'd2);
    check("bp_first_code", 32'(q_code(0)), 32'd1);
    check("bp_final_code", 32'(q_code(1)), 32'd0);
    check("bp_overrun_sticky", 32'(ovr), 32'h1);

    // Long hold on lane 1
    do_reset();
    ready = 1'b1;
    align_tick();
    sw[1] = 1'b1;
    repeat (70) @(negedge clk);
    check("hold_first_code", 32'(q_code(0)), 32'd1);
`ifdef SWITCH_LONG_PRESS_EN
    check("hold_event_count", 32'(id_q.size()), 32'd2);
    check("hold_long_code", 32'(q_code(1)), 32'd2);
    check("hold_long_id", 32'(q_id(1)), 32'd1);
`else
    check("hold_event_count", 32'(id_q.size()), 32'd1);
`endif

    // Reset in the middle of a handshake
    do_reset();
    sw[2] = 1'b1;
    repeat (25) @(negedge clk);
    check("mid_valid_before_reset", 32'(ev_valid), 32'h1);
    check("mid_id_before_reset", 32'(ev_id), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(ev_valid), 32'h0);
    check("async_switch", 32'(sw_out), 32'h0);
    check("async_id", 32'(ev_id), 32'h0);
    check("async_code", 32'(ev_code), 32'h0);
    sw = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ev_valid !== 1'b0) bad = 1'b1;
    end
    check("post_reset_no_event", 32'(bad), 32'h0);
    ready = 1'b1;
    sw[2] = 1'b1;
    repeat (25) @(negedge clk);
    check("post_reset_new_count", 32'(id_q.size()), 32'd1);
    check("post_reset_new_id", 32'(q_id(0)), 32'd2);
    check("post_reset_new_code", 32'(q_code(0)), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
